// File: rtl/mantissa_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : mantissa_alu_seq
// Purpose  : Sequential significand datapath for the FPU. Adds, subtracts
//            (magnitude) or multiplies (shift-add, one multiplier bit per
//            cycle) two MW-bit significands. The result is presented as an
//            MW+GUARD+1 bit word with guard bits and a sticky flag, ready
//            for normalise/round.
// Revision : 1.0 - initial release
// ============================================================================
module mantissa_alu_seq #(
   parameter int MW         = 24,
   parameter int GUARD      = 3,
   parameter bit EARLY_EXIT = 1'b0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [1:0]          op,
   input  logic [MW-1:0]       a,
   input  logic [MW-1:0]       b,
   output logic [MW+GUARD:0]   dout,
   output logic                sticky,
   output logic                sign,
   output logic                busy,
   output logic                done
);

   localparam int PW = 2 * MW;
   localparam int CW = (MW > 1) ? $clog2(MW) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MW - 1);
   localparam logic [1:0]    OP_SUB   = 2'b01;
   localparam logic [1:0]    OP_MUL   = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_MUL  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         op_q, op_d;
   // Multiplier shifts right so bit 0 is always the bit being processed;
   // in add/sub it simply holds operand A.
   logic [MW-1:0]      mplier_q, mplier_d;
   // Multiplicand shifts left so it is always b << i; in add/sub its low
   // MW bits hold operand B.
   logic [PW-1:0]      mcand_q, mcand_d;
   logic [PW-1:0]      prod_q, prod_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [MW+GUARD:0]  dout_q, dout_d;
   logic               sticky_q, sticky_d;
   logic               sign_q, sign_d;

   logic [MW:0]        sum;
   logic               a_ge_b;
   logic [MW-1:0]      diff;
   logic [PW-1:0]      prod_acc;
   logic               mul_last;

   assign sum      = {1'b0, mplier_q} + {1'b0, mcand_q[MW-1:0]};
   assign a_ge_b   = (mplier_q >= mcand_q[MW-1:0]);
   assign diff     = a_ge_b ? (mplier_q - mcand_q[MW-1:0])
                            : (mcand_q[MW-1:0] - mplier_q);
   assign prod_acc = prod_q + (mplier_q[0] ? mcand_q : {PW{1'b0}});
   // Early exit looks at the multiplier bits above the one being processed.
   assign mul_last = (cnt_q == CNT_LAST) ||
                     (EARLY_EXIT && (mplier_q[MW-1:1] == {(MW-1){1'b0}}));

   // Next-state and datapath update; result registers change only on entry to DONE.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      mplier_d = mplier_q;
      mcand_d  = mcand_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
      dout_d   = dout_q;
      sticky_d = sticky_q;
      sign_d   = sign_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d     = op;
               mplier_d = a;
               mcand_d  = {{MW{1'b0}}, b};
               prod_d   = '0;
               cnt_d    = '0;
               state_d  = (op == OP_MUL) ? S_MUL : S_ADD;
            end
         end
         S_ADD: begin
            if (op_q == OP_SUB) begin
               dout_d = {1'b0, diff, {GUARD{1'b0}}};
               sign_d = ~a_ge_b;
            end else begin
               // Reserved opcode 11 executes as add.
               dout_d = {sum, {GUARD{1'b0}}};
               sign_d = 1'b0;
            end
            sticky_d = 1'b0;
            state_d  = S_DONE;
         end
         S_MUL: begin
            prod_d   = prod_acc;
            mplier_d = mplier_q >> 1;
            mcand_d  = mcand_q << 1;
            cnt_d    = cnt_q + CW'(1);
            if (mul_last) begin
               dout_d   = prod_acc[PW-1:MW-GUARD-1];
               sticky_d = |prod_acc[MW-GUARD-2:0];
               sign_d   = 1'b0;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         mplier_q <= '0;
         mcand_q  <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
         dout_q   <= '0;
         sticky_q <= 1'b0;
         sign_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         mplier_q <= mplier_d;
         mcand_q  <= mcand_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
         dout_q   <= dout_d;
         sticky_q <= sticky_d;
         sign_q   <= sign_d;
      end
   end

   assign dout   = dout_q;
   assign sticky = sticky_q;
   assign sign   = sign_q;
   assign busy   = (state_q != S_IDLE);
   assign done   = (state_q == S_DONE);

endmodule
`default_nettype wire
